delay_drain_buffer: RTL and testbench
=====================================

// Module: delay_drain_buffer
// PURPOSE
//  Receive-side terminator for a ce-gated fixed-length register pipeline (DELAY stages, N bits).
//  Tags each sample entering the pipeline with a valid bit that travels alongside it.
//  Catches the pipeline output into a FIFO and presents it downstream as valid/ready.
//  Gates upstream ingestion with credits, so every in-flight sample already owns a FIFO slot.
//  The pipeline never has to stall because of downstream backpressure.
// PARAMETERS
//  N      8  data width, equals the pipeline data width
//  DELAY  4  pipeline depth in ce-advanced stages (>=1)
//  DEPTH  8  FIFO entries (>=DELAY+2 for full throughput; >=1 legal)
// PORTS
//  clk        in   1              rising-edge clock
//  rst_n      in   1              async active-low reset
//  en         in   1              pipeline advance enable
//  in_valid   in   1              upstream offers a sample to the pipeline input
//  in_ready   out  1              sample accepted this cycle (in_valid & in_ready)
//  pipe_ce    out  1              ce to every pipeline stage; equals en
//  pipe_y     in   N              pipeline tail data
//  m_data     out  N              FIFO head data
//  m_valid    out  1              FIFO non-empty
//  m_ready    in   1              downstream consumes head when m_valid & m_ready
//  level      out  clog2(DEPTH+1) FIFO occupancy
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - tag shift register, FIFO pointers, level and reserved counter all clear.
//   - Outputs: m_valid=0, level=0, in_ready=0 while rst_n=0.
//   - m_data undefined until first write.
//   - Pipeline data stages are not reset here; clearing their tags makes the stale data inert.
//  Tag shift register tag[DELAY-1:0]:
//   - On pipe_ce: tag[0] <= accept; tag[i] <= tag[i-1].
//   - Frozen when pipe_ce=0.
//  Capture: FIFO write when pipe_ce & tag[DELAY-1].
//   - Writes pipe_y as sampled in that same cycle (the value about to shift out).
//  Latency: a sample accepted at cycle t, with en held high, is written at edge t+DELAY.
//   - m_valid rises at t+DELAY (registered FIFO, no fall-through).
//  reserved = level + popcount(tag), kept as its own counter:
//   - +1 on accept, -1 on pop, net 0 when both occur.
//  in_ready = en & (reserved < DEPTH). Credit freed by a pop is usable the next cycle.
//   - There is no combinational m_ready->in_ready path.
//  Invariant reserved<=DEPTH, so a capture never finds the FIFO full.
//   - Write-while-full is an assertion failure, never silently dropped.
//  Simultaneous write and pop on the same edge: both occur, level unchanged.
//   - Also legal when level=DEPTH, since the pop frees the slot.
//  Pop when empty: ignored.
//  en=0: pipeline and tags frozen, in_ready=0; FIFO pops continue.
//  Reset mid-operation: all in-flight and buffered samples are discarded; no partial writes.
//  Pointers are log2-wide and wrap modulo DEPTH. DEPTH need not be a power of 2: wrap at DEPTH-1 -> 0.
// STRUCTURE
//  Shared package delay_lib_pkg:
//   - function clog2
//   - localparam rule PTR_W = clog2(DEPTH), CNT_W = clog2(DEPTH+1)
//  Sub-module sync_fifo (N, DEPTH):
//   - registered output, level output, async active-low reset.
//  Top holds the tag shift register, the reserved counter and the in_ready/pipe_ce logic.
// TESTING
//  Bench instantiates DELAY=4 registers on pipe_ce as the pipeline model; DEPTH=8 unless noted.
//  1 Streaming: in_valid=1 with values 0x01..0x20, m_ready=1, en=1.
//    -> m_data 0x01..0x20 in order, first m_valid 4 cycles after first accept, one word per cycle.
//  2 Backpressure: m_ready=0, in_valid=1.
//    -> exactly 8 accepts, then in_ready=0; level reaches 8 after 4 more cycles.
//    -> Raise m_ready: all 8 drain in order; in_ready returns the cycle after the first pop.
//  3 Gaps: in_valid pattern 1,0,1,1,0 with values 0xA0..0xA2.
//    -> exactly 3 FIFO writes, 0xA0,0xA1,0xA2; no bubble written.
//  4 en freeze: drop en for 5 cycles with 3 samples in flight.
//    -> no writes, tags hold, pops continue.
//    -> After en returns, remaining samples arrive DELAY minus stages already traversed.
//  5 Reset mid-flight: rst_n=0 for 1 cycle with level=5 and 3 in flight.
//    -> m_valid=0, level=0 immediately; no stale word ever emerges afterwards.
//  6 DEPTH=1, DELAY=4 corner: continuous in_valid.
//    -> one sample per 6 cycles, no overflow assertion, order preserved.

Source files
------------

// File: rtl/delay_lib_pkg.sv
// Shared helpers for the delay-pipeline receive side.
// clog2  : smallest n such that 2**n >= value (clog2(1) = 0).
// ptr_w  : FIFO pointer width for a given depth, never narrower than 1 bit.
// cnt_w  : width able to hold every occupancy 0..depth.
package delay_lib_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // A one-entry FIFO still needs a real (always-zero) pointer bit.
  function automatic int ptr_w(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return clog2(depth + 1);
  endfunction

endpackage

// File: rtl/delay_drain_buffer_sync_fifo.sv
// Synchronous FIFO with registered storage and an occupancy output.
// A word written on an edge becomes visible at the head only after that edge
// (no fall-through).
// Ports:
//   clk, rst_n          clock, async active-low reset (pointers/level only)
//   wr_en, wr_data      push one word
//   rd_en               pop the head word when non-empty
//   rd_data, rd_valid   head word and non-empty flag
//   level               current occupancy
module sync_fifo
  import delay_lib_pkg::*;
#(
  parameter int N     = 8,
  parameter int DEPTH = 8,
  localparam int PTR_W = ptr_w(DEPTH),
  localparam int CNT_W = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [N-1:0]     wr_data,
  input  logic             rd_en,
  output logic [N-1:0]     rd_data,
  output logic             rd_valid,
  output logic [CNT_W-1:0] level
);

  logic [N-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_rd;

  // Pointers wrap at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_rd    = rd_en && (count != '0);
  assign rd_data  = mem[rd_ptr];
  assign rd_valid = (count != '0);
  assign level    = count;

  // Storage is deliberately not reset; the head is undefined until written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_rd) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({wr_en, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // A write into a full FIFO is only legal when a pop frees the slot on the same edge.
  write_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(wr_en && (count == CNT_W'(DEPTH)) && !do_rd));

endmodule

// File: rtl/delay_drain_buffer.sv
// Receive-side terminator for a ce-gated fixed-length register pipeline.
// A valid tag travels beside each sample through DELAY stages; tagged samples
// leaving the pipeline are caught in a FIFO.  Ingestion is credit-gated so
// every in-flight sample already owns a FIFO slot and the pipeline never stalls.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   en                  pipeline advance enable (driven out as pipe_ce)
//   in_valid, in_ready  upstream handshake into the pipeline input
//   pipe_ce             ce to every pipeline stage
//   pipe_y              pipeline tail data
//   m_data, m_valid,
//   m_ready             downstream valid/ready from the FIFO head
//   level               FIFO occupancy
module delay_drain_buffer
  import delay_lib_pkg::*;
#(
  parameter int N     = 8,
  parameter int DELAY = 4,
  parameter int DEPTH = 8,
  localparam int CNT_W = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             pipe_ce,
  input  logic [N-1:0]     pipe_y,
  output logic [N-1:0]     m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] level
);

  logic [DELAY-1:0] tag;
  logic [CNT_W-1:0] reserved;
  logic             accept;
  logic             pop;
  logic             capture;

  assign pipe_ce = en;

  // Credits come from the registered reserved count only, so a pop frees
  // its credit on the following cycle and m_ready never reaches in_ready.
  // rst_n is included so nothing is offered as accepted while held in reset.
  assign in_ready = rst_n && en && (reserved < CNT_W'(DEPTH));
  assign accept   = in_valid && in_ready;
  assign pop      = m_valid && m_ready;
  assign capture  = pipe_ce && tag[DELAY-1];

  // Clearing the tags is what makes stale, unreset pipeline data inert.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag <= '0;
    end else if (pipe_ce) begin
      tag[0] <= accept;
      for (int i = 1; i < DELAY; i++) begin
        tag[i] <= tag[i-1];
      end
    end
  end

  // reserved tracks level plus the tagged samples still in the pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reserved <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   reserved <= reserved + CNT_W'(1);
        2'b01:   reserved <= reserved - CNT_W'(1);
        default: reserved <= reserved;
      endcase
    end
  end

  reserved_bound: assert property (@(posedge clk) disable iff (!rst_n)
    reserved <= CNT_W'(DEPTH));

  sync_fifo #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (capture),
    .wr_data  (pipe_y),
    .rd_en    (m_ready),
    .rd_data  (m_data),
    .rd_valid (m_valid),
    .level    (level)
  );

endmodule

// File: tb/tb_delay_drain_buffer.sv
// Self-checking bench for delay_drain_buffer.  Two instances share one stimulus:
// index 0 has DEPTH=8, index 1 has DEPTH=1; both have DELAY=4 with a four-register
// pipeline on pipe_ce.  Each instance carries a queue-based model compared every cycle.
module tb_delay_drain_buffer;
  import delay_lib_pkg::*;

  localparam int DELAY = 4;

  typedef struct {
    logic [7:0]  d;
    int unsigned tgt;
  } flight_t;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       in_valid;
  logic [7:0] in_data;
  logic       m_ready;

  logic [1:0]      in_ready;
  logic [1:0]      pipe_ce;
  logic [1:0]      m_valid;
  logic [1:0][7:0] m_data;
  logic [1:0][3:0] level;

  int   checks;
  int   errors;
  bit   started;

  // Monitor state for the hand-computed checks.
  int         cyc;
  int         acc0;
  int         acc1;
  int         first_acc;
  int         first_mv;
  logic [7:0] outq0 [$];
  logic [7:0] outq1 [$];
  int         popedge0 [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Drive one cycle of inputs, then return just after the following negedge.
  task automatic applyStimulus(input logic e, input logic v, input logic [7:0] d, input logic r);
    en       = e;
    in_valid = v;
    in_data  = d;
    m_ready  = r;
    @(negedge clk);
    #1;
  endtask

  task automatic clearMon();
    acc0      = 0;
    acc1      = 0;
    first_acc = -1;
    first_mv  = -1;
    outq0.delete();
    outq1.delete();
    popedge0.delete();
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int DEP = (g == 0) ? 8 : 1;
    localparam int CW  = cnt_w(DEP);

    logic [CW-1:0] lvl;
    logic [7:0]    stg [DELAY];
    flight_t       iq [$];
    logic [7:0]    fq [$];
    int unsigned   ce_cnt;

    assign level[g] = 4'(lvl);

    delay_drain_buffer #(
      .N     (8),
      .DELAY (DELAY),
      .DEPTH (DEP)
    ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .in_valid (in_valid),
      .in_ready (in_ready[g]),
      .pipe_ce  (pipe_ce[g]),
      .pipe_y   (stg[DELAY-1]),
      .m_data   (m_data[g]),
      .m_valid  (m_valid[g]),
      .m_ready  (m_ready),
      .level    (lvl)
    );

    // The external data pipeline: plain registers advanced by pipe_ce.
    always @(posedge clk) begin
      if (pipe_ce[g]) begin
        stg[0] <= in_data;
        for (int i = 1; i < DELAY; i++) begin
          stg[i] <= stg[i-1];
        end
      end
    end

    // Model: a sample accepted on the ce edge numbered k lands in the FIFO on
    // ce edge k+DELAY; credits are FIFO contents plus samples still in flight.
    always @(posedge clk or negedge rst_n) begin
      bit         acc;
      bit         pop;
      bit         wr;
      logic [7:0] wd;
      if (!rst_n) begin
        iq.delete();
        fq.delete();
      end else begin
        acc = in_valid && en && ((fq.size() + iq.size()) < DEP);
        pop = m_ready && (fq.size() != 0);
        wr  = 1'b0;
        wd  = '0;
        if (en) begin
          ce_cnt++;
          if (iq.size() != 0 && iq[0].tgt == ce_cnt) begin
            wr = 1'b1;
            wd = iq[0].d;
            void'(iq.pop_front());
          end
        end
        if (pop) void'(fq.pop_front());
        if (wr) fq.push_back(wd);
        if (acc) iq.push_back('{d: in_data, tgt: ce_cnt + DELAY});
      end
    end

    always @(negedge clk) begin
      if (started) begin
        checkOutput($sformatf("d%0d_m_valid", DEP), 32'(m_valid[g]), 32'(fq.size() != 0));
        checkOutput($sformatf("d%0d_level", DEP), 32'(level[g]), 32'(fq.size()));
        checkOutput($sformatf("d%0d_in_ready", DEP), 32'(in_ready[g]),
                    32'(rst_n && en && ((fq.size() + iq.size()) < DEP)));
        checkOutput($sformatf("d%0d_pipe_ce", DEP), 32'(pipe_ce[g]), 32'(en));
        if (fq.size() != 0) begin
          checkOutput($sformatf("d%0d_m_data", DEP), 32'(m_data[g]), 32'(fq[0]));
        end
      end
    end
  end

  always @(posedge clk) begin
    if (in_valid && in_ready[0]) begin
      acc0++;
      if (first_acc < 0) first_acc = cyc;
    end
    if (in_valid && in_ready[1]) acc1++;
    if (m_valid[0] && m_ready) begin
      outq0.push_back(m_data[0]);
      popedge0.push_back(cyc);
    end
    if (m_valid[1] && m_ready) outq1.push_back(m_data[1]);
    cyc++;
  end

  always @(negedge clk) begin
    if (m_valid[0] && first_mv < 0) first_mv = cyc - 1;
  end

  initial begin
    checks   = 0;
    errors   = 0;
    started  = 1'b0;
    cyc      = 0;
    rst_n    = 1'b0;
    en       = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    m_ready  = 1'b0;
    clearMon();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    started = 1'b1;
    checkOutput("reset_m_valid", 32'(m_valid[0]), 32'd0);
    checkOutput("reset_level", 32'(level[0]), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready[0]), 32'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // 1 Streaming 0x01..0x20
    clearMon();
    for (int i = 1; i <= 32; i++) applyStimulus(1'b1, 1'b1, 8'(i), 1'b1);
    repeat (10) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    checkOutput("stream_accepts", 32'(acc0), 32'd32);
    checkOutput("stream_latency", 32'(first_mv - first_acc), 32'd4);
    checkOutput("stream_count", 32'(outq0.size()), 32'd32);
    if (outq0.size() == 32) begin
      for (int i = 0; i < 32; i++) checkOutput("stream_data", 32'(outq0[i]), 32'(i + 1));
      checkOutput("stream_rate", 32'(popedge0[31] - popedge0[0]), 32'd31);
    end

    // 2 Backpressure
    clearMon();
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1, 8'(8'h40 + i), 1'b0);
    checkOutput("bp_accepts", 32'(acc0), 32'd8);
    checkOutput("bp_level", 32'(level[0]), 32'd8);
    checkOutput("bp_in_ready_low", 32'(in_ready[0]), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    checkOutput("bp_in_ready_back", 32'(in_ready[0]), 32'd1);
    repeat (10) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    checkOutput("bp_count", 32'(outq0.size()), 32'd8);
    if (outq0.size() == 8) begin
      for (int i = 0; i < 8; i++) checkOutput("bp_data", 32'(outq0[i]), 32'(8'h40 + i));
    end

    // 3 Gaps
    clearMon();
    applyStimulus(1'b1, 1'b1, 8'hA0, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'hEE, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'hA1, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'hA2, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'hEE, 1'b1);
    repeat (10) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    checkOutput("gap_count", 32'(outq0.size()), 32'd3);
    if (outq0.size() == 3) begin
      checkOutput("gap_w0", 32'(outq0[0]), 32'hA0);
      checkOutput("gap_w1", 32'(outq0[1]), 32'hA1);
      checkOutput("gap_w2", 32'(outq0[2]), 32'hA2);
    end

    // 4 en freeze with three samples in flight
    clearMon();
    applyStimulus(1'b1, 1'b1, 8'hB0, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'hB1, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'hC0, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'hC1, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'hC2, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b1, 8'h55, 1'b1);
    checkOutput("freeze_level", 32'(level[0]), 32'd0);
    checkOutput("freeze_pops", 32'(outq0.size()), 32'd2);
    checkOutput("freeze_accepts", 32'(acc0), 32'd5);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("thaw_level1", 32'(level[0]), 32'd1);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("thaw_level3", 32'(level[0]), 32'd3);
    repeat (8) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    checkOutput("thaw_count", 32'(outq0.size()), 32'd5);
    if (outq0.size() == 5) begin
      checkOutput("thaw_w2", 32'(outq0[2]), 32'hC0);
      checkOutput("thaw_w4", 32'(outq0[4]), 32'hC2);
    end

    // 5 Reset mid-flight: level 5, three in flight
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 8'(8'hD0 + i), 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("prerst_level", 32'(level[0]), 32'd5);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_m_valid", 32'(m_valid[0]), 32'd0);
    checkOutput("rst_level", 32'(level[0]), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready[0]), 32'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    clearMon();
    repeat (12) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    checkOutput("rst_stale_d8", 32'(outq0.size()), 32'd0);
    checkOutput("rst_stale_d1", 32'(outq1.size()), 32'd0);

    // 6 DEPTH=1: one sample per six cycles under continuous offer
    clearMon();
    for (int i = 0; i < 60; i++) applyStimulus(1'b1, 1'b1, 8'(8'h60 + i), 1'b1);
    checkOutput("d1_accepts", 32'(acc1), 32'd10);
    checkOutput("d1_count", 32'(outq1.size()), 32'd10);
    if (outq1.size() == 10) begin
      for (int k = 0; k < 10; k++) checkOutput("d1_data", 32'(outq1[k]), 32'(8'h60 + 6 * k));
    end

    // Randomized traffic against the models
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 9) != 0), $urandom_range(0, 1) == 1,
                    8'($urandom), $urandom_range(0, 3) != 0);
    end
    repeat (20) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
